// File: rtl/shift_register_4bit.sv
// Parameterised shift/load register with serial-out, saturating shift counter, zero flag.
// Latency: one cycle; every rising edge out of reset performs a load (shift=0) or a shift (shift=1).
// Backpressure: none; the register accepts a load or shift on every edge.
// Optional feature: define SHIFT_REGISTER_4BIT_ROTATE_EN to feed the shifted-out bit back in (rotate).
module shift_register_4bit #(
  parameter int WIDTH = 4,  // register width, 2..32
  parameter int DIR   = 0   // 0: shift toward MSB, 1: shift toward LSB
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low
  input  logic             shift,        // 1: shift one place, 0: parallel load
  input  logic [WIDTH-1:0] data_input,   // load data; bit 0 doubles as serial-in
  output logic [WIDTH-1:0] data_output,
  output logic             serial_out,
  output logic [7:0]       shift_count,
  output logic             zero
);

  logic             out_bit;   // bit that leaves the register on a shift
  logic             sin;       // bit that enters the register on a shift
  logic [WIDTH-1:0] shifted;   // register contents after a one-place shift

  // Pick the exiting bit by direction and the entering bit by mode.
  always_comb begin
    out_bit = (DIR == 0) ? data_output[WIDTH-1] : data_output[0];
`ifdef SHIFT_REGISTER_4BIT_ROTATE_EN
    sin     = out_bit;
`else
    sin     = data_input[0];
`endif
  end

  // Direction is a build-time choice, so the shift network is fixed wiring.
  generate
    if (DIR == 0) begin : g_left
      assign shifted = {data_output[WIDTH-2:0], sin};
    end else begin : g_right
      assign shifted = {sin, data_output[WIDTH-1:1]};
    end
  endgenerate

  // Register, serial-out and counter update; reset clears everything without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_output <= '0;
      serial_out  <= 1'b0;
      shift_count <= 8'd0;
    end else if (shift) begin
      data_output <= shifted;
      serial_out  <= out_bit;
      // Saturate so long shift runs never alias back to a small count.
      if (shift_count != 8'hFF) begin
        shift_count <= shift_count + 8'd1;
      end
    end else begin
      // Load: serial_out keeps the last bit shifted out.
      data_output <= data_input;
      shift_count <= 8'd0;
    end
  end

  assign zero = (data_output == '0);

endmodule

// File: tb/tb_shift_register_4bit.sv
// Self-checking bench: DIR=0 and DIR=1 instances share inputs, checked against tables and a model.
// Clock period 10; inputs change on falling edges, outputs sampled 1 time unit after rising edges.
// The reference model works on plain integers (multiply/divide by two, masking).
module tb_shift_register_4bit;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic       clk;
  logic       reset;
  logic       shift;
  logic [3:0] data_input;
  logic [3:0] dout0, dout1;
  logic       so0, so1;
  logic [7:0] cnt0, cnt1;
  logic       z0, z1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int m_r0, m_r1, m_so0, m_so1, m_cnt;

  typedef struct {
    logic       sh;
    logic [3:0] din;
    logic [3:0] q;
    logic       so;
    logic [7:0] cnt;
    logic       z;
  } vec_t;

  vec_t tbl [11];

  shift_register_4bit #(.WIDTH(4), .DIR(0)) u_dut0 (
    .clk(clk), .reset(reset), .shift(shift), .data_input(data_input),
    .data_output(dout0), .serial_out(so0), .shift_count(cnt0), .zero(z0)
  );

  shift_register_4bit #(.WIDTH(4), .DIR(1)) u_dut1 (
    .clk(clk), .reset(reset), .shift(shift), .data_input(data_input),
    .data_output(dout1), .serial_out(so1), .shift_count(cnt1), .zero(z1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_r0 = 0; m_r1 = 0; m_so0 = 0; m_so1 = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic sh, input logic [3:0] din);
    int ob, sin;
    if (!sh) begin
      m_r0  = int'(din);
      m_r1  = int'(din);
      m_cnt = 0;
    end else begin
      // toward MSB: double the value, new bit enters at the bottom
      ob = (m_r0 / (1 << (W - 1))) % 2;
`ifdef SHIFT_REGISTER_4BIT_ROTATE_EN
      sin = ob;
`else
      sin = int'(din[0]);
`endif
      m_r0  = (m_r0 * 2 + sin) & MASK;
      m_so0 = ob;
      // toward LSB: halve the value, new bit enters at the top
      ob = m_r1 % 2;
`ifdef SHIFT_REGISTER_4BIT_ROTATE_EN
      sin = ob;
`else
      sin = int'(din[0]);
`endif
      m_r1  = m_r1 / 2 + sin * (1 << (W - 1));
      m_so1 = ob;
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout0"}, 32'(dout0), 32'(m_r0));
    chk({tag, ".so0"},   32'(so0),   32'(m_so0));
    chk({tag, ".cnt0"},  32'(cnt0),  32'(m_cnt));
    chk({tag, ".zero0"}, 32'(z0),    32'(m_r0 == 0));
    chk({tag, ".dout1"}, 32'(dout1), 32'(m_r1));
    chk({tag, ".so1"},   32'(so1),   32'(m_so1));
    chk({tag, ".cnt1"},  32'(cnt1),  32'(m_cnt));
    chk({tag, ".zero1"}, 32'(z1),    32'(m_r1 == 0));
  endtask

  task automatic step(input logic sh, input logic [3:0] din, input string tag);
    @(negedge clk);
    shift      = sh;
    data_input = din;
    @(posedge clk);
    #1;
    model_edge(sh, din);
    check_model(tag);
  endtask

  initial begin
    // Expected DIR=0 sequence starting from the reset state
`ifdef SHIFT_REGISTER_4BIT_ROTATE_EN
    tbl[0]  = '{1'b0, 4'b1101, 4'b1101, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1010, 4'b1011, 1'b1, 8'd1, 1'b0};
    tbl[2]  = '{1'b1, 4'b0111, 4'b0111, 1'b1, 8'd2, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 8'd0, 1'b1};
    tbl[4]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 8'd1, 1'b1};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 8'd2, 1'b1};
    tbl[6]  = '{1'b0, 4'b1000, 4'b1000, 1'b0, 8'd0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0000, 4'b0001, 1'b1, 8'd1, 1'b0};
    tbl[8]  = '{1'b0, 4'b1101, 4'b1101, 1'b1, 8'd0, 1'b0};
    tbl[9]  = '{1'b1, 4'b1010, 4'b1011, 1'b1, 8'd1, 1'b0};
    tbl[10] = '{1'b1, 4'b0111, 4'b0111, 1'b1, 8'd2, 1'b0};
`else
    tbl[0]  = '{1'b0, 4'b1101, 4'b1101, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1010, 4'b1010, 1'b1, 8'd1, 1'b0};
    tbl[2]  = '{1'b1, 4'b0111, 4'b0101, 1'b1, 8'd2, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 8'd0, 1'b1};
    tbl[4]  = '{1'b1, 4'b0001, 4'b0001, 1'b0, 8'd1, 1'b0};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0010, 1'b0, 8'd2, 1'b0};
    tbl[6]  = '{1'b0, 4'b1000, 4'b1000, 1'b0, 8'd0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 8'd1, 1'b1};
    tbl[8]  = '{1'b0, 4'b1101, 4'b1101, 1'b1, 8'd0, 1'b0};
    tbl[9]  = '{1'b1, 4'b1010, 4'b1010, 1'b1, 8'd1, 1'b0};
    tbl[10] = '{1'b1, 4'b0111, 4'b0101, 1'b1, 8'd2, 1'b0};
`endif

    // Reset held low with inputs active and clock running
    reset      = 1'b1;
    shift      = 1'b0;
    data_input = 4'b1101;
    #2 reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dout0", 32'(dout0), 32'h0);
    chk("rst.so0",   32'(so0),   32'h0);
    chk("rst.cnt0",  32'(cnt0),  32'h0);
    chk("rst.zero0", 32'(z0),    32'h1);
    check_model("rst");

    @(negedge clk);
    reset = 1'b1;

    // Table-driven sequence
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].sh, tbl[i].din, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.q", i),    32'(dout0), 32'(tbl[i].q));
      chk($sformatf("tbl%0d.so", i),   32'(so0),   32'(tbl[i].so));
      chk($sformatf("tbl%0d.cnt", i),  32'(cnt0),  32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.zero", i), 32'(z0),    32'(tbl[i].z));
    end

    // Asynchronous reset between edges, no clock edge needed
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst.dout0", 32'(dout0), 32'h0);
    chk("arst.dout1", 32'(dout1), 32'h0);
    chk("arst.so0",   32'(so0),   32'h0);
    chk("arst.cnt0",  32'(cnt0),  32'h0);
    chk("arst.zero0", 32'(z0),    32'h1);
    model_reset();
    // Inputs ignored while reset is low
    shift      = 1'b1;
    data_input = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check_model("arst_hold");
    @(negedge clk);
    reset = 1'b1;

    // DIR=1 load then shift with zero serial input
    step(1'b0, 4'b1101, "dir1_load");
    step(1'b1, 4'b0000, "dir1_shift");
`ifdef SHIFT_REGISTER_4BIT_ROTATE_EN
    chk("dir1.q", 32'(dout1), 32'b1110);
`else
    chk("dir1.q", 32'(dout1), 32'b0110);
`endif
    chk("dir1.so",  32'(so1),  32'h1);
    chk("dir1.cnt", 32'(cnt1), 32'h1);

    // Counter saturation over a long shift run, then clear on load
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)), "sat");
    end
    chk("sat.cnt0", 32'(cnt0), 32'd255);
    chk("sat.cnt1", 32'(cnt1), 32'd255);
    step(1'b0, 4'b0011, "sat_load");
    chk("sat_load.cnt0", 32'(cnt0), 32'd0);

    // Randomised loads and shifts
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register_4bit.md
SHIFT_REGISTER_4BIT -- requirements
Module: shift_register_4bit

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits (legal range 2..32).
REQ-002 Parameter DIR, default 0, shift direction: 0 = toward MSB (left), 1 = toward LSB (right).
REQ-003 Port clk, input, 1 bit, single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 Port shift, input, 1 bit: 1 = shift one position, 0 = parallel load.
REQ-006 Port data_input, input, WIDTH bits: parallel load data; bit 0 is also the serial-in bit.
REQ-007 Port data_output, output, WIDTH bits: register contents, driven directly from flops.
REQ-008 Port serial_out, output, 1 bit: bit most recently shifted out.
REQ-009 Port shift_count, output, 8 bits: count of consecutive shifts since the last load or reset.
REQ-010 Port zero, output, 1 bit: 1 when data_output is all zeros; combinational from data_output.

Function
REQ-011 When shift=0 at a rising edge, data_output SHALL take data_input.
REQ-011a On the same edge, shift_count SHALL clear to 0 and serial_out SHALL hold.
REQ-012 When shift=1 and DIR=0, data_output SHALL become {data_output[WIDTH-2:0], sin}.
REQ-012a On the same edge, serial_out SHALL take the old data_output[WIDTH-1].
REQ-013 When shift=1 and DIR=1, data_output SHALL become {sin, data_output[WIDTH-1:1]}.
REQ-013a On the same edge, serial_out SHALL take the old data_output[0].
REQ-014 sin SHALL equal data_input[0], except when modified by the macro in REQ-022.
REQ-015 Latency SHALL be one cycle: the result is visible right after the edge that samples shift or the load.
REQ-016 There is no idle state; every rising edge out of reset performs either a load or a shift.
REQ-017 shift_count SHALL increment by 1 on each shift.
REQ-017a shift_count SHALL saturate at 255 and never wrap.
REQ-018 Inputs SHALL be sampled only at rising edges; changes between edges have no effect.

Reset
REQ-019 While reset=0, data_output SHALL be 0 regardless of clk, including when reset asserts mid-operation between edges.
REQ-019a While reset=0, serial_out SHALL be 0 and shift_count SHALL be 0.
REQ-019b zero SHALL be 1 while reset=0.
REQ-020 While reset=0, clk and all other inputs SHALL be ignored.
REQ-021 The first rising edge with reset=1 SHALL perform a normal load or shift; deassertion is assumed synchronous to clk by the integrator.

Configuration
REQ-022 Macro SHIFT_REGISTER_4BIT_ROTATE_EN controls rotate mode.
REQ-022a When SHIFT_REGISTER_4BIT_ROTATE_EN is defined, sin SHALL be the bit being shifted out, so a shift rotates the register.
REQ-022b When SHIFT_REGISTER_4BIT_ROTATE_EN is undefined, sin SHALL be data_input[0].
REQ-022c The macro affects shift behaviour only; loads, shift_count and reset are unchanged.

Verification (defaults WIDTH=4, DIR=0, macro undefined unless stated)
REQ-023 Reset: reset=0 with data_input=1101, clk toggling -> data_output=0000, serial_out=0, shift_count=0, zero=1.
REQ-024 Load: reset=1, shift=0, data_input=1101, one edge -> data_output=1101, zero=0, shift_count=0.
REQ-025 Shift sequence: from 1101, shift=1, data_input=1010, one edge -> data_output=1010, serial_out=1, shift_count=1.
REQ-025a Continuing with data_input=0111, one edge -> data_output=0101, serial_out=1, shift_count=2.
REQ-026 Rotate: with SHIFT_REGISTER_4BIT_ROTATE_EN defined, load 1101, then shift -> data_output=1011, serial_out=1.
REQ-026a With DIR=1, load 1101, then shift with data_input=0000 -> data_output=0110, serial_out=1.
REQ-027 Saturation: hold shift=1 for 300 edges -> shift_count stays at 255.
REQ-027a Then shift=0 for one edge -> shift_count=0.
REQ-028 Asynchronous reset mid-shift: drop reset to 0 between edges while data_output=0101 -> data_output=0000 immediately, with no clock edge needed.
